xor_descrambler32: RTL and testbench
====================================

# xor_descrambler32

Receive-side counterpart of the 32-bit XOR datapath: removes an additive xorshift32 keystream from a stream of scrambled 32-bit words. It hunts for a raw sync word, then XORs each following word with a per-word keystream until the frame length expires, and presents descrambled words on a registered valid/ready output. It sits between a word-stream source (UART/bus receive buffer) and the consumer, mirroring the scrambler on the transmit side.

## Interface
Parameters:
- SEED, 32'h2545F491, reset/default keystream seed; must be nonzero
- SYNC_WORD, 32'hA5C35A3C, raw (unscrambled) frame-start marker
- FRAME_LEN, 16, descrambled words per frame after sync (1..65535)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- seed_load  input  1  load seed_in as new seed (one-cycle pulse)
- seed_in  input  32  new seed; 0 means use SEED
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  32  scrambled word
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- out_data  output  32  descrambled word
- locked  output  1  1 while in LOCK state
- word_count  output  16  words descrambled in current frame

## Operation
- Registers: seed_reg, ks (keystream), state {HUNT, LOCK}, word_count, output register.
- xorshift32 step f(x): x ^= x<<13; x ^= x>>17; x ^= x<<5 (all 32-bit, logical shifts, truncate).
- Accept = in_valid && in_ready.
- HUNT: in_ready = 1. Accepted words never forwarded. If in_data == SYNC_WORD: state <= LOCK, ks <= seed_reg, word_count <= 0. Otherwise discard, stay HUNT.
- LOCK: in_ready = !out_valid || out_ready. On accept: out_data <= in_data ^ ks, out_valid <= 1, ks <= f(ks), word_count <= word_count+1. If word_count+1 == FRAME_LEN: state <= HUNT (that word is still output).
- A SYNC_WORD value received in LOCK is treated as data (descrambled normally).
- Output: out_valid clears when out_ready && out_valid and no new word loaded the same cycle; a simultaneous accept overwrites it and out_valid stays 1.
- seed_load (highest priority after rst): seed_reg <= (seed_in==0 ? SEED : seed_in), ks <= same value, state <= HUNT, word_count <= 0, out_valid <= 0 (pending word dropped). Input accepted that cycle is discarded.
- Keystream for frame word k (k=0..FRAME_LEN-1) is f^k(seed_reg); each sync restarts at seed_reg.

## Timing
- Reset values: in_ready 1 (HUNT), out_valid 0, out_data 0, locked 0, word_count 0, state HUNT, seed_reg = ks = SEED.
- Latency: accepted LOCK word appears on out_data the next cycle.
- Throughput: one word/cycle while out_ready held 1.
- Backpressure: out_valid=1 and out_ready=0 in LOCK forces in_ready=0; out_data/out_valid held stable until taken.
- HUNT with pending out_valid (last frame word not yet taken): output held until taken; input continues to be consumed for sync.
- locked reflects current state register; goes 1 the cycle after sync accept, 0 the cycle after last frame word accepted.
- rst mid-frame: all state returns to reset values next edge, seed_reg returns to SEED.

## Test plan
- Reset, seed_load seed_in=1, send SYNC_WORD then 32'h00000000, 32'h00000000 -> out_data 32'h00000001 then 32'h00042021; word_count 1, 2; locked=1.
- Before sync send 32'h12345678, 32'hDEADBEEF -> no out_valid, locked=0, in_ready=1 throughout.
- FRAME_LEN=2, seed 1: SYNC, D0, D1, D2 -> two outputs, locked=0 after D1, D2 discarded; next SYNC, D3=0 -> out 32'h00000001 (keystream restarted).
- Hold out_ready=0 in LOCK with in_valid=1 -> one output captured, in_ready=0, out_data stable several cycles; release -> streaming at 1 word/cycle, no loss or duplicate.
- seed_load with seed_in=0 mid-frame while out_valid=1 -> out_valid 0 next cycle, locked 0, seed_reg = 32'h2545F491; after SYNC, data 0 -> out 32'h2545F491.
- Round trip: 1000 random words scrambled by a model (ks=f^k(seed)) with random in_valid/out_ready gaps -> outputs equal originals, order preserved.

Source files
------------

// File: rtl/xor_descrambler32.sv
`timescale 1ns/1ps
// xor_descrambler32
// Receive-side additive descrambler. Hunts for a raw sync word, then XORs
// each following word with an xorshift32 keystream (restarted from seed_reg
// at every sync) until FRAME_LEN words have been produced, then hunts again.
//
// State table
//   HUNT | waiting for SYNC_WORD; every accepted word is discarded
//   LOCK | descrambling frame words; keystream advances once per word
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   seed_load   one-cycle pulse: adopt seed_in (0 selects SEED), drop frame
//   seed_in     new keystream seed
//   in_valid    in_data valid
//   in_ready    block accepts in_data this cycle
//   in_data     scrambled word
//   out_valid   out_data valid (registered)
//   out_ready   consumer accepts out_data
//   out_data    descrambled word (registered)
//   locked      1 while in LOCK
//   word_count  words descrambled in the current frame
module xor_descrambler32 #(
  parameter logic [31:0] SEED      = 32'h2545F491,
  parameter logic [31:0] SYNC_WORD = 32'hA5C35A3C,
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic [31:0] seed_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        locked,
  output logic [15:0] word_count
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [15:0] FRAME_LEN16 = 16'(FRAME_LEN);

  state_t      state, state_nxt;
  logic [31:0] seed_reg;
  logic [31:0] ks;
  logic [15:0] wc;
  logic [31:0] out_q;
  logic        out_v;
  logic        rdy;
  logic        sync_hit;
  logic        lock_accept;
  logic [31:0] seed_sel;

  function automatic logic [31:0] xs32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // A zero seed would lock the xorshift generator at zero forever.
  assign seed_sel = (seed_in == 32'h0) ? SEED : seed_in;

  always_comb begin
    state_nxt   = state;
    rdy         = 1'b1;
    sync_hit    = 1'b0;
    lock_accept = 1'b0;
    case (state)
      HUNT: begin
        rdy = 1'b1;
        if (in_valid && (in_data == SYNC_WORD)) begin
          sync_hit  = 1'b1;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        // Only stall when a finished word is still waiting for the consumer.
        rdy = !out_v || out_ready;
        if (in_valid && rdy) begin
          lock_accept = 1'b1;
          if ((wc + 16'd1) == FRAME_LEN16) begin
            state_nxt = HUNT;
          end
        end
      end
      default: begin
        state_nxt = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      seed_reg <= SEED;
      ks       <= SEED;
      wc       <= 16'd0;
      out_v    <= 1'b0;
      out_q    <= 32'h0;
    end else if (seed_load) begin
      // Reseeding abandons the frame, including any word not yet taken.
      seed_reg <= seed_sel;
      ks       <= seed_sel;
      state    <= HUNT;
      wc       <= 16'd0;
      out_v    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (sync_hit) begin
        ks <= seed_reg;
        wc <= 16'd0;
      end
      if (lock_accept) begin
        out_q <= in_data ^ ks;
        out_v <= 1'b1;
        ks    <= xs32(ks);
        wc    <= wc + 16'd1;
      end else if (out_v && out_ready) begin
        out_v <= 1'b0;
      end
    end
  end

  assign in_ready   = rdy;
  assign out_valid  = out_v;
  assign out_data   = out_q;
  assign locked     = (state == LOCK);
  assign word_count = wc;

endmodule

// File: tb/tb_xor_descrambler32.sv
`timescale 1ns/1ps
module tb_xor_descrambler32;

  localparam logic [31:0] SEED = 32'h2545F491;
  localparam logic [31:0] SYNC = 32'hA5C35A3C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance a: default FRAME_LEN=16, instance b: FRAME_LEN=2
  logic        seed_load_a = 1'b0, seed_load_b = 1'b0;
  logic [31:0] seed_in_a = '0, seed_in_b = '0;
  logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic [31:0] in_data_a = '0, in_data_b = '0;
  logic        out_ready_a = 1'b1, out_ready_b = 1'b1;
  logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [31:0] out_data_a, out_data_b;
  logic        locked_a, locked_b;
  logic [15:0] wc_a, wc_b;

  xor_descrambler32 u_a (
    .clk(clk), .rst(rst), .seed_load(seed_load_a), .seed_in(seed_in_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .locked(locked_a), .word_count(wc_a)
  );

  xor_descrambler32 #(.FRAME_LEN(2)) u_b (
    .clk(clk), .rst(rst), .seed_load(seed_load_b), .seed_in(seed_in_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .locked(locked_b), .word_count(wc_b)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] mon_exp_a, mon_exp_b;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [31:0] ks_at(input logic [31:0] s, input int k);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < k; i++) v = xs(v);
    return v;
  endfunction

  // scoreboard monitor: pops one expectation per completed output transfer
  always @(negedge clk) begin
    if (out_valid_a && out_ready_a) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL mon_a unexpected output actual=%h expected=none", out_data_a);
      end else begin
        mon_exp_a = qa.pop_front();
        if (out_data_a !== mon_exp_a) begin
          errors++;
          $display("FAIL mon_a out_data actual=%h expected=%h", out_data_a, mon_exp_a);
        end
      end
    end
    if (out_valid_b && out_ready_b) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL mon_b unexpected output actual=%h expected=none", out_data_b);
      end else begin
        mon_exp_b = qb.pop_front();
        if (out_data_b !== mon_exp_b) begin
          errors++;
          $display("FAIL mon_b out_data actual=%h expected=%h", out_data_b, mon_exp_b);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic rnd_ready(input bit rnd);
    if (rnd) out_ready_a = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n, input bit rnd);
    repeat (n) begin
      @(posedge clk); #1;
      rnd_ready(rnd);
    end
  endtask

  // called and returns at posedge+1; expectation is queued once the word is accepted
  task automatic send(input int sel, input logic [31:0] d, input bit has_exp,
                      input logic [31:0] exp, input bit rnd, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    if (sel == 0) begin in_valid_a = 1'b1; in_data_a = d; end
    else          begin in_valid_b = 1'b1; in_data_b = d; end
    while (!ok && waited <= 200) begin
      @(negedge clk);
      if ((sel == 0) ? in_ready_a : in_ready_b) ok = 1'b1;
      else begin
        waited++;
        @(posedge clk); #1;
        rnd_ready(rnd);
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout sel=%0d data=%h actual=stalled expected=accepted", sel, d);
    end else if (has_exp) begin
      if (sel == 0) qa.push_back(exp);
      else          qb.push_back(exp);
    end
    @(posedge clk); #1;
    if (sel == 0) in_valid_a = 1'b0;
    else          in_valid_b = 1'b0;
  endtask

  task automatic seed_pulse(input int sel, input logic [31:0] s);
    if (sel == 0) begin seed_load_a = 1'b1; seed_in_a = s; end
    else          begin seed_load_b = 1'b1; seed_in_b = s; end
    @(posedge clk); #1;
    seed_load_a = 1'b0;
    seed_load_b = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready_a = 1'b1;
    out_ready_b = 1'b1;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d/%0d pending expected=0", qa.size(), qb.size());
    end
  endtask

  initial begin
    int w;
    int k;
    logic [31:0] ks;
    logic [31:0] word;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", {31'h0, in_ready_a}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid_a}, 32'h0);
    check("rst_out_data", out_data_a, 32'h0);
    check("rst_locked", {31'h0, locked_a}, 32'h0);
    check("rst_word_count", {16'h0, wc_a}, 32'h0);

    // FRAME_LEN=2: frame end, trailing word discarded, keystream restart
    seed_pulse(1, 32'h1);
    send(1, SYNC, 1'b0, 32'h0, 1'b0, w);
    send(1, 32'h0, 1'b1, 32'h00000001, 1'b0, w);
    send(1, 32'h0, 1'b1, 32'h00042021, 1'b0, w);
    check("b_locked_after_last", {31'h0, locked_b}, 32'h0);
    check("b_word_count_last", {16'h0, wc_b}, 32'h2);
    send(1, 32'h00000077, 1'b0, 32'h0, 1'b0, w);
    check("b_d2_in_ready_wait", w, 0);
    check("b_locked_after_d2", {31'h0, locked_b}, 32'h0);
    send(1, SYNC, 1'b0, 32'h0, 1'b0, w);
    check("b_relock", {31'h0, locked_b}, 32'h1);
    send(1, 32'h0, 1'b1, 32'h00000001, 1'b0, w);
    idle(2, 1'b0);

    // words before sync are swallowed
    send(0, 32'h12345678, 1'b0, 32'h0, 1'b0, w);
    check("hunt_in_ready_0", w, 0);
    check("hunt_locked_0", {31'h0, locked_a}, 32'h0);
    check("hunt_out_valid_0", {31'h0, out_valid_a}, 32'h0);
    send(0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, w);
    check("hunt_in_ready_1", w, 0);
    check("hunt_locked_1", {31'h0, locked_a}, 32'h0);
    check("hunt_out_valid_1", {31'h0, out_valid_a}, 32'h0);

    // seed 1, first two keystream words
    seed_pulse(0, 32'h1);
    send(0, SYNC, 1'b0, 32'h0, 1'b0, w);
    check("sync_locked", {31'h0, locked_a}, 32'h1);
    check("sync_word_count", {16'h0, wc_a}, 32'h0);
    send(0, 32'h0, 1'b1, 32'h00000001, 1'b0, w);
    check("wc_1", {16'h0, wc_a}, 32'h1);
    send(0, 32'h0, 1'b1, 32'h00042021, 1'b0, w);
    check("wc_2", {16'h0, wc_a}, 32'h2);
    check("locked_mid", {31'h0, locked_a}, 32'h1);
    idle(2, 1'b0);

    // backpressure: one word captured, input stalled, output stable
    out_ready_a = 1'b0;
    send(0, 32'h0, 1'b1, 32'h04080601, 1'b0, w);
    in_valid_a = 1'b1;
    in_data_a  = 32'hFFFFFFFF;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready", {31'h0, in_ready_a}, 32'h0);
      check("bp_out_valid", {31'h0, out_valid_a}, 32'h1);
      check("bp_out_data", out_data_a, 32'h04080601);
    end
    @(posedge clk); #1;
    out_ready_a = 1'b1;
    for (int i = 3; i < 8; i++) begin
      word = 32'hFFFFFFFF - 32'(i);
      send(0, word, 1'b1, word ^ ks_at(32'h1, i), 1'b0, w);
      check("stream_nowait", w, 0);
    end
    check("stream_wc", {16'h0, wc_a}, 32'h8);
    idle(2, 1'b0);

    // reseed to default mid-frame with a pending word
    out_ready_a = 1'b0;
    send(0, 32'h5A5A5A5A, 1'b1, 32'h5A5A5A5A ^ ks_at(32'h1, 8), 1'b0, w);
    check("pend_out_valid", {31'h0, out_valid_a}, 32'h1);
    seed_pulse(0, 32'h0);
    void'(qa.pop_back());
    check("seed0_out_valid", {31'h0, out_valid_a}, 32'h0);
    check("seed0_locked", {31'h0, locked_a}, 32'h0);
    check("seed0_wc", {16'h0, wc_a}, 32'h0);
    out_ready_a = 1'b1;
    send(0, SYNC, 1'b0, 32'h0, 1'b0, w);
    send(0, 32'h0, 1'b1, SEED, 1'b0, w);
    idle(2, 1'b0);

    // reset mid-frame restores default seed
    seed_pulse(0, 32'h1);
    send(0, SYNC, 1'b0, 32'h0, 1'b0, w);
    send(0, 32'h0, 1'b1, 32'h00000001, 1'b0, w);
    idle(2, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_in_ready", {31'h0, in_ready_a}, 32'h1);
    check("mrst_out_valid", {31'h0, out_valid_a}, 32'h0);
    check("mrst_out_data", out_data_a, 32'h0);
    check("mrst_locked", {31'h0, locked_a}, 32'h0);
    check("mrst_wc", {16'h0, wc_a}, 32'h0);
    send(0, SYNC, 1'b0, 32'h0, 1'b0, w);
    send(0, 32'h0, 1'b1, SEED, 1'b0, w);
    send(0, 32'h0, 1'b1, xs(SEED), 1'b0, w);
    idle(2, 1'b0);
    drain();

    // round trip with random gaps and random consumer stalls
    seed_pulse(0, 32'h1234ABCD);
    k = 0;
    ks = 32'h1234ABCD;
    for (int i = 0; i < 1000; i++) begin
      if (k == 0) begin
        send(0, SYNC, 1'b0, 32'h0, 1'b1, w);
        ks = 32'h1234ABCD;
      end
      if ($urandom_range(0, 3) == 0) idle(1, 1'b1);
      word = $urandom;
      send(0, word ^ ks, 1'b1, word, 1'b1, w);
      ks = xs(ks);
      k = (k + 1) % 16;
    end
    drain();
    idle(2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
